// File: rtl/rf_sb_pkg.sv
// rf_sb_pkg: default geometry shared by the scoreboarded register file, its interface and entries.
package rf_sb_pkg;
    localparam int DEF_REG_LEN     = 16;
    localparam int DEF_RF_SIZE     = 4;
    localparam int DEF_RF_SIZE_LOG = 2;
    localparam int DEF_TAG_LEN     = 3;
    localparam int DEF_NUM_RD      = 2;
    localparam int DEF_NUM_WR      = 2;
endpackage

// File: rtl/rf_sb_if.sv
// rf_sb_if: flattened read, alloc, writeback and flush buses of the scoreboarded register file.
interface rf_sb_if import rf_sb_pkg::*; #(
    parameter int REG_LEN     = DEF_REG_LEN,
    parameter int RF_SIZE_LOG = DEF_RF_SIZE_LOG,
    parameter int TAG_LEN     = DEF_TAG_LEN,
    parameter int NUM_RD      = DEF_NUM_RD,
    parameter int NUM_WR      = DEF_NUM_WR
) ();
    logic [NUM_RD*RF_SIZE_LOG-1:0] rd_addr;
    logic [NUM_RD*REG_LEN-1:0]     rd_data;
    logic [NUM_RD-1:0]             rd_busy;
    logic [NUM_RD*TAG_LEN-1:0]     rd_tag;
    logic                          alloc_en;
    logic [RF_SIZE_LOG-1:0]        alloc_rd;
    logic [TAG_LEN-1:0]            alloc_tag;
    logic [NUM_WR-1:0]             wb_en;
    logic [NUM_WR*RF_SIZE_LOG-1:0] wb_rd;
    logic [NUM_WR*TAG_LEN-1:0]     wb_tag;
    logic [NUM_WR*REG_LEN-1:0]     wb_data;
    logic                          flush;
    modport master (
        output rd_addr, alloc_en, alloc_rd, alloc_tag, wb_en, wb_rd, wb_tag, wb_data, flush,
        input  rd_data, rd_busy, rd_tag
    );
    modport slave (
        input  rd_addr, alloc_en, alloc_rd, alloc_tag, wb_en, wb_rd, wb_tag, wb_data, flush,
        output rd_data, rd_busy, rd_tag
    );
endinterface

// File: rtl/rf_sb_entry.sv
// rf_sb_entry: one register's data, busy bit and producer tag.
// Priority on the scoreboard: flush > alloc > matching writeback; data always follows the highest hit port.
module rf_sb_entry import rf_sb_pkg::*; #(
    parameter int REG_LEN = DEF_REG_LEN,
    parameter int TAG_LEN = DEF_TAG_LEN,
    parameter int NUM_WR  = DEF_NUM_WR
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_WR-1:0]         hit_i,
    input  logic [NUM_WR*TAG_LEN-1:0] wb_tag_i,
    input  logic [NUM_WR*REG_LEN-1:0] wb_data_i,
    input  logic                      alloc_i,
    input  logic [TAG_LEN-1:0]        alloc_tag_i,
    input  logic                      flush_i,
    output logic [REG_LEN-1:0]        data_o,
    output logic                      busy_o,
    output logic [TAG_LEN-1:0]        tag_o
);
    logic [REG_LEN-1:0] data_q, data_d;
    logic               busy_q, busy_d;
    logic [TAG_LEN-1:0] tag_q, tag_d;

    always_comb begin
        data_d = data_q;
        busy_d = busy_q;
        tag_d  = tag_q;
        for (int w = 0; w < NUM_WR; w++) begin
            if (hit_i[w]) begin
                data_d = wb_data_i[w*REG_LEN +: REG_LEN];
                busy_d = (busy_q && wb_tag_i[w*TAG_LEN +: TAG_LEN] == tag_q) ? 1'b0 : busy_d;
            end
        end
        busy_d = flush_i ? 1'b0 : alloc_i ? 1'b1 : busy_d;
        tag_d  = (!flush_i && alloc_i) ? alloc_tag_i : tag_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= '0;
            busy_q <= 1'b0;
            tag_q  <= '0;
        end else begin
            data_q <= data_d;
            busy_q <= busy_d;
            tag_q  <= tag_d;
        end
    end

    assign data_o = data_q;
    assign busy_o = busy_q;
    assign tag_o  = tag_q;
endmodule

// File: rtl/rf_sb.sv
// rf_sb: multi-port register file with per-register busy/tag scoreboard.
// Define RF_SB_BYPASS_EN to forward same-cycle writeback data and busy release onto the read ports.
module rf_sb import rf_sb_pkg::*; #(
    parameter int REG_LEN     = DEF_REG_LEN,
    parameter int RF_SIZE     = DEF_RF_SIZE,
    parameter int RF_SIZE_LOG = DEF_RF_SIZE_LOG,
    parameter int TAG_LEN     = DEF_TAG_LEN,
    parameter int NUM_RD      = DEF_NUM_RD,
    parameter int NUM_WR      = DEF_NUM_WR
) (
    input logic    clk,
    input logic    rst,
    rf_sb_if.slave bus
);
    localparam int AW = RF_SIZE_LOG;

    logic [REG_LEN-1:0] data [RF_SIZE];
    logic [RF_SIZE-1:0] busy;
    logic [TAG_LEN-1:0] tag  [RF_SIZE];

    for (genvar i = 0; i < RF_SIZE; i++) begin : g_ent
        logic [NUM_WR-1:0] hit;
        for (genvar w = 0; w < NUM_WR; w++) begin : g_hit
            assign hit[w] = bus.wb_en[w] && bus.wb_rd[w*AW +: AW] == AW'(i);
        end
        rf_sb_entry #(
            .REG_LEN(REG_LEN),
            .TAG_LEN(TAG_LEN),
            .NUM_WR (NUM_WR)
        ) u_entry (
            .clk        (clk),
            .rst        (rst),
            .hit_i      (hit),
            .wb_tag_i   (bus.wb_tag),
            .wb_data_i  (bus.wb_data),
            .alloc_i    (bus.alloc_en && bus.alloc_rd == AW'(i)),
            .alloc_tag_i(bus.alloc_tag),
            .flush_i    (bus.flush),
            .data_o     (data[i]),
            .busy_o     (busy[i]),
            .tag_o      (tag[i])
        );
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [AW-1:0]      a;
        logic [REG_LEN-1:0] d;
        logic               b;
        assign a = bus.rd_addr[p*AW +: AW];
        always_comb begin
            d = data[a];
            b = busy[a];
`ifdef RF_SB_BYPASS_EN
            for (int w = 0; w < NUM_WR; w++) begin
                if (bus.wb_en[w] && bus.wb_rd[w*AW +: AW] == a) begin
                    d = bus.wb_data[w*REG_LEN +: REG_LEN];
                    b = (busy[a] && bus.wb_tag[w*TAG_LEN +: TAG_LEN] == tag[a]) ? 1'b0 : b;
                end
            end
`endif
        end
        assign bus.rd_data[p*REG_LEN +: REG_LEN] = d;
        assign bus.rd_busy[p]                    = b;
        assign bus.rd_tag[p*TAG_LEN +: TAG_LEN]  = tag[a];
    end
endmodule

// File: tb/tb_rf_sb.sv
// tb_rf_sb: directed self-checking bench for rf_sb; expectations follow RF_SB_BYPASS_EN when defined.
module tb_rf_sb;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    rf_sb_if bus ();
    rf_sb dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alloc_en  = 1'b0;
        bus.alloc_rd  = '0;
        bus.alloc_tag = '0;
        bus.wb_en     = '0;
        bus.wb_rd     = '0;
        bus.wb_tag    = '0;
        bus.wb_data   = '0;
        bus.flush     = 1'b0;
    endtask

    task automatic wb(input int port, input logic [1:0] rd, input logic [2:0] t, input logic [15:0] d);
        bus.wb_en[port]          = 1'b1;
        bus.wb_rd[port*2 +: 2]   = rd;
        bus.wb_tag[port*3 +: 3]  = t;
        bus.wb_data[port*16 +: 16] = d;
    endtask

    task automatic alloc(input logic [1:0] rd, input logic [2:0] t);
        bus.alloc_en  = 1'b1;
        bus.alloc_rd  = rd;
        bus.alloc_tag = t;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle();
        bus.rd_addr = {2'd2, 2'd1};
        #1;
        checks++;
        if (bus.rd_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp %h", bus.rd_data, 32'h0); end
        checks++;
        if (bus.rd_busy !== 2'b00 || bus.rd_tag !== 6'h0) begin errors++; $display("FAIL reset_sb got busy %b tag %h exp 00/0", bus.rd_busy, bus.rd_tag); end
        #10;
        rst = 1'b1;
        wb(0, 2'd1, 3'd0, 16'h1234);
        alloc(2'd2, 3'd5);
        tick();
        idle();
        checks++;
        if (bus.rd_data[15:0] !== 16'h1234) begin errors++; $display("FAIL pre_reset_r1 got %h exp %h", bus.rd_data[15:0], 16'h1234); end
        checks++;
        if (bus.rd_busy[1] !== 1'b1 || bus.rd_tag[5:3] !== 3'd5) begin errors++; $display("FAIL pre_reset_r2 got busy %b tag %0d exp 1/5", bus.rd_busy[1], bus.rd_tag[5:3]); end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.rd_data !== 32'h0) begin errors++; $display("FAIL async_reset_data got %h exp %h", bus.rd_data, 32'h0); end
        checks++;
        if (bus.rd_busy !== 2'b00 || bus.rd_tag !== 6'h0) begin errors++; $display("FAIL async_reset_sb got busy %b tag %h exp 00/0", bus.rd_busy, bus.rd_tag); end
        #1;
        rst = 1'b1;
    endtask

    task automatic test_alloc_wb();
        bus.rd_addr = {2'd0, 2'd2};
        alloc(2'd2, 3'd3);
        tick();
        idle();
        checks++;
        if (bus.rd_busy[0] !== 1'b1 || bus.rd_tag[2:0] !== 3'd3) begin errors++; $display("FAIL alloc_r2 got busy %b tag %0d exp 1/3", bus.rd_busy[0], bus.rd_tag[2:0]); end
        wb(0, 2'd2, 3'd3, 16'hBEEF);
        tick();
        idle();
        checks++;
        if (bus.rd_busy[0] !== 1'b0 || bus.rd_data[15:0] !== 16'hBEEF) begin errors++; $display("FAIL wb_r2 got busy %b data %h exp 0/beef", bus.rd_busy[0], bus.rd_data[15:0]); end
    endtask

    task automatic test_stale_wb();
        bus.rd_addr = {2'd0, 2'd1};
        alloc(2'd1, 3'd2);
        tick();
        alloc(2'd1, 3'd4);
        tick();
        idle();
        wb(1, 2'd1, 3'd2, 16'h0011);
        tick();
        idle();
        checks++;
        if (bus.rd_data[15:0] !== 16'h0011) begin errors++; $display("FAIL stale_data got %h exp %h", bus.rd_data[15:0], 16'h0011); end
        checks++;
        if (bus.rd_busy[0] !== 1'b1 || bus.rd_tag[2:0] !== 3'd4) begin errors++; $display("FAIL stale_sb got busy %b tag %0d exp 1/4", bus.rd_busy[0], bus.rd_tag[2:0]); end
    endtask

    task automatic test_conflicts();
        bus.rd_addr = {2'd0, 2'd3};
        wb(0, 2'd3, 3'd0, 16'hAAAA);
        wb(1, 2'd3, 3'd0, 16'h5555);
        tick();
        idle();
        checks++;
        if (bus.rd_data[15:0] !== 16'h5555) begin errors++; $display("FAIL wb_priority got %h exp %h", bus.rd_data[15:0], 16'h5555); end
        alloc(2'd3, 3'd1);
        tick();
        idle();
        alloc(2'd3, 3'd6);
        wb(0, 2'd3, 3'd1, 16'h7777);
        tick();
        idle();
        checks++;
        if (bus.rd_busy[0] !== 1'b1 || bus.rd_tag[2:0] !== 3'd6 || bus.rd_data[15:0] !== 16'h7777) begin
            errors++;
            $display("FAIL alloc_vs_wb got busy %b tag %0d data %h exp 1/6/7777", bus.rd_busy[0], bus.rd_tag[2:0], bus.rd_data[15:0]);
        end
    endtask

    task automatic test_flush();
        bus.rd_addr = {2'd1, 2'd0};
        alloc(2'd0, 3'd1);
        tick();
        alloc(2'd1, 3'd2);
        tick();
        idle();
        checks++;
        if (bus.rd_busy !== 2'b11) begin errors++; $display("FAIL pre_flush_busy got %b exp 11", bus.rd_busy); end
        bus.flush = 1'b1;
        alloc(2'd2, 3'd1);
        wb(0, 2'd0, 3'd7, 16'h4242);
        tick();
        idle();
        checks++;
        if (bus.rd_busy !== 2'b00 || bus.rd_data[15:0] !== 16'h4242) begin errors++; $display("FAIL flush_r0r1 got busy %b data %h exp 00/4242", bus.rd_busy, bus.rd_data[15:0]); end
        bus.rd_addr = {2'd3, 2'd2};
        #1;
        checks++;
        if (bus.rd_busy !== 2'b00) begin errors++; $display("FAIL flush_r2r3 got busy %b exp 00", bus.rd_busy); end
    endtask

    task automatic test_bypass();
        bus.rd_addr = {2'd0, 2'd1};
        alloc(2'd1, 3'd5);
        tick();
        idle();
        wb(0, 2'd1, 3'd5, 16'h0F0F);
        #1;
`ifdef RF_SB_BYPASS_EN
        checks++;
        if (bus.rd_data[15:0] !== 16'h0F0F || bus.rd_busy[0] !== 1'b0) begin errors++; $display("FAIL bypass_match got data %h busy %b exp 0f0f/0", bus.rd_data[15:0], bus.rd_busy[0]); end
`else
        checks++;
        if (bus.rd_data[15:0] !== 16'h0011 || bus.rd_busy[0] !== 1'b1) begin errors++; $display("FAIL no_bypass_match got data %h busy %b exp 0011/1", bus.rd_data[15:0], bus.rd_busy[0]); end
`endif
        tick();
        idle();
        checks++;
        if (bus.rd_data[15:0] !== 16'h0F0F || bus.rd_busy[0] !== 1'b0) begin errors++; $display("FAIL after_wb_r1 got data %h busy %b exp 0f0f/0", bus.rd_data[15:0], bus.rd_busy[0]); end
        alloc(2'd1, 3'd6);
        tick();
        idle();
        wb(1, 2'd1, 3'd2, 16'hABCD);
        #1;
`ifdef RF_SB_BYPASS_EN
        checks++;
        if (bus.rd_data[15:0] !== 16'hABCD || bus.rd_busy[0] !== 1'b1) begin errors++; $display("FAIL bypass_stale got data %h busy %b exp abcd/1", bus.rd_data[15:0], bus.rd_busy[0]); end
`else
        checks++;
        if (bus.rd_data[15:0] !== 16'h0F0F || bus.rd_busy[0] !== 1'b1) begin errors++; $display("FAIL no_bypass_stale got data %h busy %b exp 0f0f/1", bus.rd_data[15:0], bus.rd_busy[0]); end
`endif
        tick();
        idle();
        checks++;
        if (bus.rd_data[15:0] !== 16'hABCD || bus.rd_busy[0] !== 1'b1 || bus.rd_tag[2:0] !== 3'd6) begin
            errors++;
            $display("FAIL after_stale_r1 got data %h busy %b tag %0d exp abcd/1/6", bus.rd_data[15:0], bus.rd_busy[0], bus.rd_tag[2:0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp [4];
        for (int i = 0; i < 4; i++) begin
            idle();
            exp[i] = 16'hC000 + 16'(i * 16'h0101);
            wb(i % 2, 2'(i), 3'd0, exp[i]);
            tick();
        end
        idle();
        for (int i = 0; i < 4; i += 2) begin
            bus.rd_addr = {2'(i + 1), 2'(i)};
            #1;
            checks++;
            if (bus.rd_data !== {exp[i+1], exp[i]}) begin errors++; $display("FAIL b2b_r%0d_r%0d got %h exp %h", i, i + 1, bus.rd_data, {exp[i+1], exp[i]}); end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_alloc_wb();
        test_stale_wb();
        test_conflicts();
        test_flush();
        test_bypass();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
